display_multiplexado: RTL and testbench
=======================================

// Module: display_multiplexado
// PURPOSE
//  Parametrised multiplexed 7-segment display driver for the microwave front panel.
//  Scans NUM_DIGITS common-anode digits from one packed 4-bit code bus.
//  Provides glyphs 0-9 and F/I/N/P/A, per-digit blanking, blinking and decimal point.
//  Double-buffers input codes so an update never tears mid-frame.
// PARAMETERS
//  NUM_DIGITS  4           number of digits scanned, legal range 1..8
//  SCAN_DIV    50000       clk cycles per digit slot, >= 2
//  BLINK_DIV   12500000    clk cycles per blink half-period, >= 2
// PORTS
//  clk         in   1              system clock, all logic on its rising edge
//  rst_n       in   1              asynchronous, active-low reset
//  codes       in   4*NUM_DIGITS   digit codes; nibble i drives digit i (digit 0 = LSB nibble)
//  dp_in       in   NUM_DIGITS     decimal point request per digit, 1 = on
//  load        in   1              1-cycle strobe: capture codes/dp_in into the pending buffer
//  blank_mask  in   NUM_DIGITS     1 = force digit off (live, not buffered)
//  blink_mask  in   NUM_DIGITS     1 = digit blinks (live, not buffered)
//  seg         out  7              segments GFEDCBA, active-low
//  dp          out  1              decimal point, active-low
//  an          out  NUM_DIGITS     digit enables, active-low, at most one low at a time
//  frame_tick  out  1              1-cycle pulse when the scan wraps to digit 0
// BEHAVIOUR
//  Reset (async, rst_n=0): an all 1; seg=7'b1111111; dp=1; frame_tick=0.
//   Digit index, prescaler and blink counter cleared; blink_phase=0.
//   Shadow codes all 4'hF (blank); shadow dp all 0; pending flag 0.
//  Glyph table, GFEDCBA active-low:
//   0=1000000  1=1111001  2=0100100  3=0110000  4=0011001
//   5=0010010  6=0000010  7=1111000  8=0000000  9=0010000
//   A=0001110 (F)  B=1001111 (I)  C=0101011 (N)  D=0001100 (P)  E=0001000 (A)  F=1111111 (off)
//  Prescaler: counts 0..SCAN_DIV-1 and wraps.
//   At terminal count the digit index advances; index NUM_DIGITS-1 wraps to 0.
//   Wrap is the frame boundary: frame_tick=1 on the following cycle only.
//  Ghost guard: while prescaler==0, an is all 1; seg/dp hold the new digit's values.
//  Outputs are registered: seg/dp/an reflect index/prescaler with 1-cycle latency.
//  Digit i is shown (an[i]=0) when all hold: i==index, prescaler!=0, blank_mask[i]=0,
//   and NOT (blink_mask[i]=1 AND blink_phase=1). Otherwise an[i]=1.
//  dp = ~shadow_dp[index], forced to 1 whenever the digit is not shown.
//  Blink: counter counts 0..BLINK_DIV-1; blink_phase toggles at terminal count.
//   Free-running, independent of the scan.
//  Double buffer:
//   load=1 copies codes/dp_in into pending and sets the pending flag.
//   At the frame boundary with the flag set: pending copies to shadow, flag clears.
//   A second load before the boundary overwrites pending (last wins).
//   load on the boundary cycle itself writes codes straight to shadow; flag clears.
//  NUM_DIGITS=1: index stays 0; frame_tick pulses every SCAN_DIV cycles.
//  Reset mid-scan: all outputs go to reset values immediately; a pending load is discarded.
// TESTING (NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=64)
//  1 Hold rst_n=0 for 5 cycles, release, no load
//    -> an=4'hF, seg=7'h7F, dp=1 throughout; frame_tick every 16 cycles.
//  2 load codes=16'h1234, dp_in=4'b0010
//    -> after next frame_tick: an=1110 gives seg=0011001 dp=1; an=1101 gives seg=0110000 dp=0.
//  3 load codes=16'hEDCB -> digits 0..3 show I, N, P, A
//    -> seg=1001111, 0101011, 0001100, 0001000.
//  4 Mid-frame load 16'h1111, then 16'h2222 before wrap
//    -> display unchanged until frame_tick, then all digits seg=0100100.
//  5 blink_mask=0001, blank_mask=1000 -> an[3] never 0;
//    an[0] low only while blink_phase=0 (64-cycle windows); an never has two zeros.
//  6 rst_n pulsed low mid-slot right after a load
//    -> outputs reset same cycle; shadow returns to blank; pending load not applied.

Source files
------------

// File: rtl/display_multiplexado.sv
// Multiplexed 7-segment driver for the microwave front panel.
// Scans NUM_DIGITS common-anode digits and decodes 4-bit glyph codes.
// Incoming codes are double-buffered so a frame is never torn.
// seg/dp/an/frame_tick are all registered.
module display_multiplexado #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 12500000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] codes,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int BLK_W = $clog2(BLINK_DIV);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  // Glyph decode, GFEDCBA active-low; code F (and anything unknown) is dark.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001110; // F
      4'hB:    g = 7'b1001111; // I
      4'hC:    g = 7'b0101011; // N
      4'hD:    g = 7'b0001100; // P
      4'hE:    g = 7'b0001000; // A
      4'hF:    g = 7'b1111111; // off
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  // Scan state
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             scan_last_s;
  logic             wrap_s;

  // Blink state
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;

  // Double buffer
  logic [4*NUM_DIGITS-1:0] pend_codes_q, pend_codes_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_flag_q, pend_flag_d;
  logic [4*NUM_DIGITS-1:0] shadow_codes_q, shadow_codes_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;

  // Output registers
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_tick_q;
  logic [3:0]            sel_code_s;
  logic                  sel_dp_s;

  // Prescaler and digit index advance; wrap_s marks the frame boundary edge.
  always_comb begin
    presc_d     = presc_q;
    idx_d       = idx_q;
    scan_last_s = (presc_q == PRE_LAST);
    wrap_s      = scan_last_s && (idx_q == IDX_LAST);
    if (scan_last_s) begin
      presc_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      presc_d = presc_q + PRE_W'(1);
    end
  end

  // Free-running blink half-period counter.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLK_W'(1);
    end
  end

  // Pending/shadow buffer: shadow only changes on the frame boundary edge.
  always_comb begin
    pend_codes_d   = pend_codes_q;
    pend_dp_d      = pend_dp_q;
    pend_flag_d    = pend_flag_q;
    shadow_codes_d = shadow_codes_q;
    shadow_dp_d    = shadow_dp_q;
    if (wrap_s) begin
      pend_flag_d = 1'b0;
      if (load) begin
        shadow_codes_d = codes;
        shadow_dp_d    = dp_in;
      end else if (pend_flag_q) begin
        shadow_codes_d = pend_codes_q;
        shadow_dp_d    = pend_dp_q;
      end else begin
        shadow_codes_d = shadow_codes_q;
      end
    end else if (load) begin
      pend_codes_d = codes;
      pend_dp_d    = dp_in;
      pend_flag_d  = 1'b1;
    end else begin
      pend_flag_d = pend_flag_q;
    end
  end

  // Select the current digit's code/dp and decide which anode (if any) is driven.
  always_comb begin
    sel_code_s = 4'hF;
    sel_dp_s   = 1'b0;
    an_d       = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_code_s = shadow_codes_q[4*i +: 4];
        sel_dp_s   = shadow_dp_q[i];
        an_d[i]    = ~((presc_q != '0) && !blank_mask[i] &&
                       !(blink_mask[i] && blink_phase_q));
      end else begin
        an_d[i] = 1'b1;
      end
    end
    seg_d = glyph(sel_code_s);
    if (an_d != '1) begin
      dp_d = ~sel_dp_s;
    end else begin
      dp_d = 1'b1;
    end
  end

  // Scan, blink and buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q        <= '0;
      idx_q          <= '0;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      pend_codes_q   <= '1;
      pend_dp_q      <= '0;
      pend_flag_q    <= 1'b0;
      shadow_codes_q <= '1;
      shadow_dp_q    <= '0;
    end else begin
      presc_q        <= presc_d;
      idx_q          <= idx_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      pend_codes_q   <= pend_codes_d;
      pend_dp_q      <= pend_dp_d;
      pend_flag_q    <= pend_flag_d;
      shadow_codes_q <= shadow_codes_d;
      shadow_dp_q    <= shadow_dp_d;
    end
  end

  // Registered display outputs and frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_tick_q <= wrap_s;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_multiplexado.sv
// Self-checking bench for display_multiplexado (4 digits, SCAN_DIV=4, BLINK_DIV=64).
// Expected outputs come from a cycle-count model: scan position and blink phase
// are derived arithmetically from edges since reset release.
module tb_display_multiplexado;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int BD    = 64;
  localparam int FRAME = ND * SD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] codes;
  logic [3:0]  dp_in;
  logic        load;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference glyph table, GFEDCBA active-low.
  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001110, 7'b1001111,
    7'b0101011, 7'b0001100, 7'b0001000, 7'b1111111};

  // Model state
  logic [15:0] m_code, m_pcode;
  logic [3:0]  m_dp, m_pdp;
  logic        m_pflag;
  int          k;

  always #5 clk = ~clk;

  display_multiplexado #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .codes(codes), .dp_in(dp_in), .load(load),
    .blank_mask(blank_mask), .blink_mask(blink_mask),
    .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t k=%0d: got %0h expected %0h", tag, $time, k, got, exp);
    end
  endtask

  task automatic model_reset();
    m_code  = 16'hFFFF;
    m_dp    = 4'h0;
    m_pcode = 16'hFFFF;
    m_pdp   = 4'h0;
    m_pflag = 1'b0;
    k       = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an"},  32'(an),         32'hF);
    chk({tag, "_seg"}, 32'(seg),        32'h7F);
    chk({tag, "_dp"},  32'(dp),         32'h1);
    chk({tag, "_ft"},  32'(frame_tick), 32'h0);
  endtask

  // One clock: predict outputs from the model, advance the buffer model, compare.
  task automatic step();
    int p, ix, ph;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_dp, e_ft;
    p     = k % SD;
    ix    = (k / SD) % ND;
    ph    = (k / BD) % 2;
    e_seg = glyph_tab[m_code[4*ix +: 4]];
    e_an  = 4'hF;
    if (p != 0 && !blank_mask[ix] && !(blink_mask[ix] && ph == 1)) e_an[ix] = 1'b0;
    e_dp  = (e_an != 4'hF) ? ~m_dp[ix] : 1'b1;
    e_ft  = ((k % FRAME) == FRAME - 1);
    if ((k % FRAME) == FRAME - 1) begin
      if (load) begin
        m_code = codes;
        m_dp   = dp_in;
      end else if (m_pflag) begin
        m_code = m_pcode;
        m_dp   = m_pdp;
      end
      m_pflag = 1'b0;
    end else if (load) begin
      m_pcode = codes;
      m_pdp   = dp_in;
      m_pflag = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("seg", 32'(seg), 32'(e_seg));
    chk("an", 32'(an), 32'(e_an));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("frame_tick", 32'(frame_tick), 32'(e_ft));
    chk("an_single", 32'($countones(~an) <= 1), 32'h1);
    k++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic load_word(input logic [15:0] c, input logic [3:0] d);
    codes = c;
    dp_in = d;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    while ((k % FRAME) != ph) step();
  endtask

  initial begin
    rst_n      = 1'b0;
    load       = 1'b0;
    codes      = 16'h0000;
    dp_in      = 4'h0;
    blank_mask = 4'h0;
    blink_mask = 4'h0;
    model_reset();

    // 1: reset held, then free-running with nothing loaded
    repeat (5) begin
      @(posedge clk);
      #1;
      chk_reset("rst_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    run(40);

    // 2: digits 4 3 2 1 with dp on digit 1
    wait_phase(6);
    load_word(16'h1234, 4'b0010);
    run(40);

    // 3: letters I N P A
    load_word(16'hEDCB, 4'b0000);
    run(36);

    // 4: two loads within one frame, last one wins at the boundary
    wait_phase(3);
    load_word(16'h1111, 4'b0001);
    wait_phase(9);
    load_word(16'h2222, 4'b0100);
    run(36);

    // Load exactly on the boundary cycle goes straight to shadow
    wait_phase(FRAME - 1);
    load_word(16'h90AB, 4'b1001);
    run(20);

    // 5: blink digit 0, blank digit 3 across several blink windows
    load_word(16'h8888, 4'b1111);
    blink_mask = 4'b0001;
    blank_mask = 4'b1000;
    run(200);

    // Randomized traffic: random loads, codes and masks
    for (int c = 0; c < 400; c++) begin
      if ((c % 50) == 0) begin
        blank_mask = 4'($urandom);
        blink_mask = 4'($urandom);
      end
      if ($urandom_range(0, 9) == 0) begin
        load_word(16'($urandom), 4'($urandom));
      end else begin
        step();
      end
    end
    blank_mask = 4'h0;
    blink_mask = 4'h0;

    // 6: reset mid-slot straight after a load; pending data must be dropped
    wait_phase(5);
    step();
    load_word(16'h5678, 4'hF);
    rst_n = 1'b0;
    #1;
    chk_reset("rst_async");
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_reset("rst_mid");
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
